// File: rtl/note_pkg.sv
// Note-word layout, end-of-channel marker and sequencer state encoding.
// Latency: none; this file holds constants and types only.
// Backpressure: not applicable.
package note_pkg;

    localparam int SONG_W    = 2;
    localparam int PITCH_MSB = 15;
    localparam int PITCH_LSB = 10;
    localparam int PITCH_W   = PITCH_MSB - PITCH_LSB + 1;
    localparam int DUR_W     = 10;

    localparam logic [DUR_W-1:0] END_DUR = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD0,
        LOAD1,
        RUN
    } seq_state_t;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } note_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters, with a rotating priority pointer.
// Latency: the grant is combinational; the pointer moves on the edge that accepts the grant.
// Backpressure: the pointer holds whenever advance is low.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic          grant_vld,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] prio;
    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(prio) + i) % N);
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio <= '0;
        end else if (advance && grant_vld) begin
            prio <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/note_fetch_sequencer.sv
// Multiple playback channels share one note-memory read port; each channel fetches its next note when its duration expires.
// Latency: start to first read strobe is 2 cycles; a note word lands in ch_pitch 2 cycles after its read strobe.
// Backpressure: none; one read per cycle, and channels waiting on a fetch drop ticks.
module note_fetch_sequencer
    import note_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SONG_W = note_pkg::SONG_W,
    parameter int ADDR_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [SONG_W-1:0]         song,
    input  logic                      tick,
    output logic [SONG_W-1:0]         pos_song,
    input  logic [NUM_CH*ADDR_W-1:0]  pos_base,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [15:0]               mem_data,
    output logic [NUM_CH*PITCH_W-1:0] ch_pitch,
    output logic [NUM_CH-1:0]         ch_active,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    seq_state_t         state;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  active;
    logic [NUM_CH-1:0]  in_flight;
    logic [NUM_CH-1:0]  arb_req;
    logic [NUM_CH-1:0]  grant;
    logic [ADDR_W-1:0]  ptr    [NUM_CH];
    logic [ADDR_W-1:0]  base   [NUM_CH];
    logic [DUR_W-1:0]   remain [NUM_CH];
    logic [PITCH_W-1:0] pitch  [NUM_CH];
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rd_tag;
    logic [IDX_W-1:0]   ret_tag;
    logic               grant_vld;
    logic               issue;
    logic               ret_vld;
    note_t              ret_note;

    assign ret_note  = note_t'(mem_data);
    assign busy      = (state != IDLE);
    assign ch_active = active;

    always_comb begin
        base      = '{default: '0};
        ch_pitch  = '0;
        in_flight = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = pos_base[c*ADDR_W +: ADDR_W];
            ch_pitch[c*PITCH_W +: PITCH_W] = pitch[c];
            in_flight[c] = (mem_rd && rd_tag == IDX_W'(c)) ||
                           (ret_vld && ret_tag == IDX_W'(c));
        end
    end

    // The first grant is issued on the LOAD1 edge itself, treating every channel as requesting.
    always_comb begin
        arb_req = '0;
        if (state == LOAD1) begin
            arb_req = '1;
        end else if (state == RUN) begin
            arb_req = req;
        end
    end

    assign issue = grant_vld && !stop && !start;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (arb_req),
        .advance   (issue),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pos_song <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            done     <= 1'b0;
            req      <= '0;
            active   <= '0;
            ret_vld  <= 1'b0;
            rd_tag   <= '0;
            ret_tag  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ptr[c]    <= '0;
                remain[c] <= '0;
                pitch[c]  <= '0;
            end
        end else begin
            done    <= 1'b0;
            mem_rd  <= issue;
            ret_vld <= mem_rd;
            ret_tag <= rd_tag;
            if (issue) begin
                rd_tag   <= grant_idx;
                mem_addr <= (state == LOAD1) ? base[grant_idx] : ptr[grant_idx];
            end

            if (stop) begin
                state    <= IDLE;
                req      <= '0;
                active   <= '0;
                ret_vld  <= 1'b0;
                mem_addr <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    pitch[c] <= '0;
                end
            end else if (start) begin
                state    <= LOAD0;
                pos_song <= song;
                ret_vld  <= 1'b0;
            end else begin
                case (state)
                    LOAD0: state <= LOAD1;
                    LOAD1: begin
                        state  <= RUN;
                        active <= '1;
                        req    <= ~grant;
                        for (int c = 0; c < NUM_CH; c++) begin
                            ptr[c]    <= base[c];
                            remain[c] <= '0;
                            pitch[c]  <= '0;
                        end
                    end
                    RUN: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (tick && active[c] && !req[c] && !in_flight[c] &&
                                remain[c] != '0) begin
                                remain[c] <= remain[c] - 1'b1;
                                if (remain[c] == DUR_W'(1)) begin
                                    req[c] <= 1'b1;
                                end
                            end
                        end
                        if (issue) begin
                            req[grant_idx] <= 1'b0;
                        end
                        if (ret_vld) begin
                            if (ret_note.dur == END_DUR) begin
                                active[ret_tag] <= 1'b0;
                                pitch[ret_tag]  <= '0;
                            end else begin
                                pitch[ret_tag]  <= ret_note.pitch;
                                remain[ret_tag] <= ret_note.dur;
                                ptr[ret_tag]    <= ptr[ret_tag] + 1'b1;
                            end
                        end
                        if (active == '0 && !mem_rd && !ret_vld) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_fetch_sequencer.sv
// Self-checking bench: a table of start-up vectors, hand-written tick, end, stop, restart and reset sequences,
// and a read-address scoreboard fed by a small note-memory model and a position-ROM model.
module tb_note_fetch_sequencer;

    localparam int NUM_CH = 4;
    localparam int SONG_W = 2;
    localparam int ADDR_W = 16;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     stop;
    logic                     tick;
    logic [SONG_W-1:0]        song;
    logic [SONG_W-1:0]        pos_song;
    logic [NUM_CH*ADDR_W-1:0] pos_base;
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [15:0]              mem_data;
    logic [NUM_CH*6-1:0]      ch_pitch;
    logic [NUM_CH-1:0]        ch_active;
    logic                     busy;
    logic                     done;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0]        exp_rd_q [$];
    logic [ADDR_W-1:0]        mon_exp;
    logic [15:0]              mem [256];
    logic [NUM_CH*ADDR_W-1:0] rom [4];

    typedef struct {
        logic        start;
        logic [23:0] pitch;
        logic        rd;
        logic [3:0]  act;
        logic        busy;
    } vec_t;

    vec_t vec [8];

    always #5 clock = ~clock;

    note_fetch_sequencer #(
        .NUM_CH (NUM_CH),
        .SONG_W (SONG_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .song      (song),
        .tick      (tick),
        .pos_song  (pos_song),
        .pos_base  (pos_base),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ch_pitch  (ch_pitch),
        .ch_active (ch_active),
        .busy      (busy),
        .done      (done)
    );

    // Registered position ROM and note memory.
    always @(posedge clock) begin
        pos_base <= rom[pos_song];
        if (mem_rd) mem_data <= mem[mem_addr[7:0]];
    end

    // Scoreboard: every read strobe must match the next expected address.
    always @(negedge clock) begin
        if (reset !== 1'b1 && mem_rd === 1'b1) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_order: read of addr %0d, no read expected", mem_addr);
            end else begin
                mon_exp = exp_rd_q.pop_front();
                if (mem_addr !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_order: read addr %0d, expected %0d", mem_addr, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tk();
        @(posedge clock);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        tk();
        tick = 1'b0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_pos_song"}, 32'(pos_song), 32'd0);
        chk({p, "_mem_rd"},   32'(mem_rd),   32'd0);
        chk({p, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({p, "_pitch"},    32'(ch_pitch), 32'd0);
        chk({p, "_active"},   32'(ch_active), 32'd0);
        chk({p, "_busy"},     32'(busy),     32'd0);
        chk({p, "_done"},     32'(done),     32'd0);
    endtask

    initial begin
        int ndone;
        int nrd;
        int done_at;

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
        song  = '0;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1403;  // pitch 5, dur 3
        mem[10]  = 16'h1403;
        mem[20]  = 16'h1403;
        mem[30]  = 16'h1403;
        mem[1]   = 16'h1C03;  // pitch 7, dur 3
        mem[11]  = 16'h2401;  // pitch 9, dur 1
        mem[21]  = 16'h1400;  // end marker
        mem[31]  = 16'h2C02;  // pitch 11, dur 2
        mem[100] = 16'h0C05;  // pitch 3
        mem[110] = 16'h1005;  // pitch 4
        mem[120] = 16'h1805;  // pitch 6
        mem[130] = 16'h2005;  // pitch 8
        rom[0] = {16'd30, 16'd20, 16'd10, 16'd0};
        rom[1] = '0;
        rom[2] = {16'd130, 16'd120, 16'd110, 16'd100};
        rom[3] = '0;

        vec[0] = '{1'b1, 24'h000000, 1'b0, 4'h0, 1'b1};
        vec[1] = '{1'b0, 24'h000000, 1'b0, 4'h0, 1'b1};
        vec[2] = '{1'b0, 24'h000000, 1'b1, 4'hF, 1'b1};
        vec[3] = '{1'b0, 24'h000000, 1'b1, 4'hF, 1'b1};
        vec[4] = '{1'b0, 24'h000005, 1'b1, 4'hF, 1'b1};
        vec[5] = '{1'b0, 24'h000145, 1'b1, 4'hF, 1'b1};
        vec[6] = '{1'b0, 24'h005145, 1'b0, 4'hF, 1'b1};
        vec[7] = '{1'b0, 24'h145145, 1'b0, 4'hF, 1'b1};

        repeat (2) tk();
        chk_reset_vals("rst");
        reset = 1'b0;
        tk();

        // Start-up from reset: pointer at channel 0, reads 0,10,20,30.
        exp_rd_q.push_back(16'd0);
        exp_rd_q.push_back(16'd10);
        exp_rd_q.push_back(16'd20);
        exp_rd_q.push_back(16'd30);
        for (int i = 0; i < 8; i++) begin
            start = vec[i].start;
            tk();
            chk($sformatf("vec%0d_pitch", i),  32'(ch_pitch),  32'(vec[i].pitch));
            chk($sformatf("vec%0d_rd", i),     32'(mem_rd),    32'(vec[i].rd));
            chk($sformatf("vec%0d_active", i), 32'(ch_active), 32'(vec[i].act));
            chk($sformatf("vec%0d_busy", i),   32'(busy),      32'(vec[i].busy));
            chk($sformatf("vec%0d_done", i),   32'(done),      32'd0);
        end
        start = 1'b0;
        chk("startup_q_empty", 32'(exp_rd_q.size()), 32'd0);

        // Duration expiry and four-way contention on the third tick.
        do_tick();
        repeat (7) tk();
        do_tick();
        chk("tick2_pitch0", 32'(ch_pitch[5:0]), 32'd5);
        repeat (7) tk();
        exp_rd_q.push_back(16'd1);
        exp_rd_q.push_back(16'd11);
        exp_rd_q.push_back(16'd21);
        exp_rd_q.push_back(16'd31);
        do_tick();
        chk("tick3_hold_pitch", 32'(ch_pitch), 32'h145145);
        chk("tick3_no_rd_yet",  32'(mem_rd),   32'd0);
        tk();
        chk("expiry_rd",   32'(mem_rd),   32'd1);
        chk("expiry_addr", 32'(mem_addr), 32'd1);
        tk();
        chk("expiry_pitch_old", 32'(ch_pitch[5:0]), 32'd5);
        tk();
        chk("expiry_pitch_new", 32'(ch_pitch[5:0]), 32'd7);
        tk();
        tk();
        chk("end_ch2_active", 32'(ch_active),       32'b1011);
        chk("end_ch2_pitch",  32'(ch_pitch[17:12]), 32'd0);
        tk();
        chk("contention_q_empty", 32'(exp_rd_q.size()), 32'd0);
        chk("contention_pitch", 32'(ch_pitch), 32'({6'd11, 6'd0, 6'd9, 6'd7}));
        chk("contention_done",  32'(done),     32'd0);
        tk();

        exp_rd_q.push_back(16'd12);
        do_tick();
        repeat (7) tk();
        chk("ch1_end_active", 32'(ch_active), 32'b1001);
        chk("ch1_end_pitch",  32'(ch_pitch),  32'({6'd11, 6'd0, 6'd0, 6'd7}));

        exp_rd_q.push_back(16'd32);
        do_tick();
        repeat (7) tk();
        chk("ch3_end_active", 32'(ch_active), 32'b0001);
        chk("ch3_end_pitch",  32'(ch_pitch),  32'd7);

        exp_rd_q.push_back(16'd2);
        do_tick();
        ndone   = 0;
        done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tk();
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        chk("done_cycle",  32'(done_at),   32'd4);
        chk("done_count",  32'(ndone),     32'd1);
        chk("done_busy",   32'(busy),      32'd0);
        chk("done_active", 32'(ch_active), 32'd0);
        chk("done_pitch",  32'(ch_pitch),  32'd0);
        chk("done_q_empty", 32'(exp_rd_q.size()), 32'd0);

        // Stop in the cycle a return is due; pointer now favours channel 1.
        exp_rd_q.push_back(16'd10);
        exp_rd_q.push_back(16'd20);
        song  = 2'd0;
        start = 1'b1;
        tk();
        start = 1'b0;
        repeat (3) tk();
        stop = 1'b1;
        tk();
        stop = 1'b0;
        chk("stop_pitch",  32'(ch_pitch),  32'd0);
        chk("stop_active", 32'(ch_active), 32'd0);
        chk("stop_busy",   32'(busy),      32'd0);
        chk("stop_rd",     32'(mem_rd),    32'd0);
        chk("stop_addr",   32'(mem_addr),  32'd0);
        ndone = 0;
        nrd   = 0;
        for (int k = 0; k < 6; k++) begin
            tk();
            if (done === 1'b1) ndone++;
            if (mem_rd === 1'b1) nrd++;
        end
        chk("stop_no_done", 32'(ndone), 32'd0);
        chk("stop_no_rd",   32'(nrd),   32'd0);
        chk("stop_pitch_after", 32'(ch_pitch), 32'd0);
        chk("stop_q_empty", 32'(exp_rd_q.size()), 32'd0);

        // Start song 0 with pointer at channel 3, then restart with song 2 mid-RUN.
        exp_rd_q.push_back(16'd30);
        exp_rd_q.push_back(16'd0);
        exp_rd_q.push_back(16'd10);
        exp_rd_q.push_back(16'd20);
        start = 1'b1;
        tk();
        start = 1'b0;
        repeat (7) tk();
        chk("rs0_pitch",   32'(ch_pitch), 32'h145145);
        chk("rs0_q_empty", 32'(exp_rd_q.size()), 32'd0);
        exp_rd_q.push_back(16'd130);
        exp_rd_q.push_back(16'd100);
        exp_rd_q.push_back(16'd110);
        exp_rd_q.push_back(16'd120);
        song  = 2'd2;
        start = 1'b1;
        tk();
        start = 1'b0;
        chk("rs2_pos_song", 32'(pos_song), 32'd2);
        chk("rs2_busy",     32'(busy),     32'd1);
        repeat (7) tk();
        chk("rs2_pitch",   32'(ch_pitch),  32'({6'd8, 6'd6, 6'd4, 6'd3}));
        chk("rs2_active",  32'(ch_active), 32'hF);
        chk("rs2_q_empty", 32'(exp_rd_q.size()), 32'd0);

        // Reset mid-RUN, then confirm the pointer is back at channel 0.
        reset = 1'b1;
        tk();
        chk_reset_vals("midrst");
        reset = 1'b0;
        song  = 2'd0;
        exp_rd_q.push_back(16'd0);
        exp_rd_q.push_back(16'd10);
        exp_rd_q.push_back(16'd20);
        exp_rd_q.push_back(16'd30);
        start = 1'b1;
        tk();
        start = 1'b0;
        repeat (7) tk();
        chk("post_rst_pitch",   32'(ch_pitch), 32'h145145);
        chk("post_rst_q_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
